// File: rtl/mod_timer.sv
// mod_timer: memory-mapped down-counting timer with an 8-bit prescaler.
//
// All state updates on the falling edge of clk. Reset is synchronous and
// active-low.
//
// Ports
//   clk      in   1  clock; state changes on negedge
//   rst      in   1  synchronous active-low reset
//   ie       in   1  instruction-bus enable (unused)
//   de       in   1  data-bus enable, qualifies writes
//   iaddr    in  32  instruction address (unused)
//   daddr    in  32  block-relative byte offset
//   drw      in   2  read/write; bit0 set means write
//   din      in  32  write data
//   iout     out 32  instruction read data, always 0 (block is not executable)
//   dout     out 32  data read data, combinational decode of daddr
//   tmr_int  out  1  registered single-cycle expiry pulse
//
// Register map
//   0x0 COUNT   R/W
//   0x4 RELOAD  R/W
//   0x8 CTRL    R/W  bit0 EN, bit1 PER (1 periodic), bits[15:8] DIV
//   0xC STATUS  bit0 EXP, sticky, write-1-to-clear

module mod_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        ie,
    input  logic        de,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [1:0]  drw,
    input  logic [31:0] din,
    output logic [31:0] iout,
    output logic [31:0] dout,
    output logic        tmr_int
);

    localparam logic [31:0] AddrCount  = 32'h0000_0000;
    localparam logic [31:0] AddrReload = 32'h0000_0004;
    localparam logic [31:0] AddrCtrl   = 32'h0000_0008;
    localparam logic [31:0] AddrStatus = 32'h0000_000C;

    logic [31:0] count_q,  count_d;
    logic [31:0] reload_q, reload_d;
    logic        en_q,     en_d;
    logic        per_q,    per_d;
    logic [7:0]  div_q,    div_d;
    logic        exp_q,    exp_d;
    logic [7:0]  presc_q,  presc_d;
    logic        int_q,    int_d;

    logic wr;
    logic count_wr;
    logic reload_wr;
    logic ctrl_wr;
    logic status_wr;
    logic tick;
    logic expire;

    // Inputs that the block never looks at.
    logic unused_inputs;
    assign unused_inputs = ^{ie, iaddr, drw[1]};

    // ------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------
    assign wr        = de & drw[0];
    assign count_wr  = wr && (daddr == AddrCount);
    assign reload_wr = wr && (daddr == AddrReload);
    assign ctrl_wr   = wr && (daddr == AddrCtrl);
    assign status_wr = wr && (daddr == AddrStatus);

    // ------------------------------------------------------------------
    // Tick and expiry
    // ------------------------------------------------------------------
    assign tick   = en_q && (presc_q == div_q);
    // A COUNT write on the tick cycle takes precedence and cancels expiry.
    assign expire = tick && (count_q == 32'd0) && !count_wr;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        en_d     = en_q;
        per_d    = per_q;
        div_d    = div_q;
        exp_d    = exp_q;
        presc_d  = presc_q;
        int_d    = 1'b0;

        // Prescaler: any CTRL write restarts it; otherwise it runs only
        // while enabled and wraps to 0 on the tick.
        if (ctrl_wr) begin
            presc_d = 8'd0;
        end else if (en_q) begin
            presc_d = tick ? 8'd0 : presc_q + 8'd1;
        end

        // COUNT: bus write wins over the tick's decrement or reload.
        if (count_wr) begin
            count_d = din;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (per_q) begin
                // Uses the pre-write RELOAD, so a coincident RELOAD write
                // only affects the following period.
                count_d = reload_q;
            end
        end

        if (reload_wr) begin
            reload_d = din;
        end

        // CTRL: a write always wins; otherwise one-shot expiry stops the timer.
        if (ctrl_wr) begin
            en_d  = din[0];
            per_d = din[1];
            div_d = din[15:8];
        end else if (expire && !per_q) begin
            en_d = 1'b0;
        end

        // EXP: setting beats a coincident write-1-to-clear.
        if (expire) begin
            exp_d = 1'b1;
        end else if (status_wr && din[0]) begin
            exp_d = 1'b0;
        end

        // With DIV=0 and RELOAD=0 expiry can fire every cycle; suppress the
        // pulse right after one so tmr_int is never high two cycles running.
        int_d = expire && !int_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(negedge clk) begin
        if (!rst) begin
            count_q  <= 32'd0;
            reload_q <= 32'd0;
            en_q     <= 1'b0;
            per_q    <= 1'b0;
            div_q    <= 8'd0;
            exp_q    <= 1'b0;
            presc_q  <= 8'd0;
            int_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            per_q    <= per_d;
            div_q    <= div_d;
            exp_q    <= exp_d;
            presc_q  <= presc_d;
            int_q    <= int_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        dout = 32'd0;
        case (daddr)
            AddrCount:  dout = count_q;
            AddrReload: dout = reload_q;
            AddrCtrl:   dout = {16'd0, div_q, 6'd0, per_q, en_q};
            AddrStatus: dout = {31'd0, exp_q};
            default:    dout = 32'd0;
        endcase
    end

    assign iout    = 32'd0;
    assign tmr_int = int_q;

endmodule
